seven_seg_digit_entry: RTL
==========================

# seven_seg_digit_entry

Button-driven two-digit decimal entry block for the DE10-Lite board. The user presses KEY[0] to step the selected digit and KEY[1] to advance or commit. The block drives HEX4 (Digit1, tens) and HEX5 (Digit2, ones) with encoded seven-segment patterns and presents the committed binary value to downstream logic such as the month/day calculator. It performs the inverse of the segment-to-decimal decode path: it encodes decimal digits into HEX segment patterns.

## Interface
- DEBOUNCE_CYCLES, 250000: number of consecutive synchronized cycles a button level must hold before it is accepted; must be ≥1.
- BLINK_CYCLES, 12500000: half-period of the selected-digit blink, in cycles. Used only with ENTRY_BLINK_EN.
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- KEY  in  2  raw push buttons, active-low (0 = pressed). KEY[0] = increment, KEY[1] = advance/commit.
- HEX4  out  8  Digit1 (tens) segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- HEX5  out  8  Digit2 (ones) segments, same format as HEX4.
- value  out  7  committed value tens*10+ones, range 0–99.
- done  out  1  one-cycle pulse when value is committed.
- LEDR  out  2  state indicator: 01 = EDIT_TENS, 10 = EDIT_ONES, 11 = DONE.

## Operation
- Per-key input path:
  - 2-flop synchronizer.
  - Stability counter: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A "press" is a 1→0 transition of the debounced level.
- FSM states: EDIT_TENS, EDIT_ONES, DONE.
  - EDIT_TENS: press0 → tens = (tens+1) mod 10. press1 → EDIT_ONES.
  - EDIT_ONES: press0 → ones = (ones+1) mod 10. press1 → DONE; value ← tens*10+ones; done = 1 for one cycle.
  - DONE: press0 is ignored. press1 → EDIT_TENS; digits are retained and value is held.
- Simultaneous press0 and press1 in the same cycle: press1 acts, press0 is discarded.
- Holding a button produces a single press. There is no auto-repeat.
- Segment encoding (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Blank = FF.
- value is computed as an unsigned 7-bit result; max 99, no overflow.
- Reset values: tens=0, ones=0, state EDIT_TENS, value=0, done=0, LEDR=01, debounced levels=1 (released), counters=0. HEX reset values are listed under Configuration.
- Reset mid-operation: all of the above are restored on the next clk edge, regardless of state or button level. A button held through reset release is not a press.

## Timing
- KEY first sampled low at edge N:
  - debounced level falls at edge N+2+DEBOUNCE_CYCLES;
  - digit and state registers update at N+3+DEBOUNCE_CYCLES;
  - HEX4, HEX5, value, done and LEDR update at N+4+DEBOUNCE_CYCLES.
- All outputs are registered; there are no combinational paths from input to output.
- done is high for exactly one cycle per commit.
- value is stable from that cycle until the next commit or reset.
- Release (0→1) uses the same debounce latency and generates no action.

## Configuration
- ENTRY_BLINK_EN defined:
  - Includes a free-running blink counter, period 2*BLINK_CYCLES, reset to 0.
  - In EDIT_TENS or EDIT_ONES, the selected digit shows its pattern during the first BLINK_CYCLES cycles and blank (FF) during the second BLINK_CYCLES cycles.
  - The unselected digit is always shown. In DONE nothing blinks.
  - dp is always off.
  - Reset: HEX4 = C0, HEX5 = C0.
- ENTRY_BLINK_EN undefined:
  - No blink counter.
  - The selected digit is indicated by its dp lit (bit7 = 0).
  - In DONE both dp are off.
  - Reset: HEX4 = 40, HEX5 = C0.

## Test plan
- Bench uses DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
- Reset: rst high 2 cycles → HEX4=40 (C0 with blink), HEX5=C0, value=0, done=0, LEDR=01.
- Wrap: 10 clean presses of KEY[0] in EDIT_TENS → tens steps 1..9 then 0; HEX4 dp-off pattern goes 90 after the 9th press, C0 after the 10th.
- Entry 42: 4×KEY[0], KEY[1], 2×KEY[0], KEY[1] → done pulses once, value=42, LEDR=11, HEX4=99, HEX5=A4.
- Bounce: KEY[0] low for 3 cycles, then high, repeated 5 times → no digit change. Then low for 10 cycles → exactly one increment, at the latency N+4+DEBOUNCE_CYCLES.
- Simultaneous: KEY[0] and KEY[1] fall on the same edge in EDIT_TENS → state EDIT_ONES, tens unchanged.
- Reset mid-entry: tens=7, state EDIT_ONES, KEY[0] held low; assert rst for 1 cycle → reset values restored, no increment after reset release while the key stays held.

Source files
------------

// File: rtl/seven_seg_digit_entry_if.sv
// Button/display bundle for the two-digit decimal entry block.
interface seven_seg_digit_entry_if;
  logic [1:0] KEY;
  logic [7:0] HEX4;
  logic [7:0] HEX5;
  logic [6:0] value;
  logic       done;
  logic [1:0] LEDR;

  modport master (output KEY, input HEX4, HEX5, value, done, LEDR);
  modport slave  (input KEY, output HEX4, HEX5, value, done, LEDR);
endinterface

// File: rtl/seven_seg_digit_entry.sv
// Two-digit decimal entry from KEY[0]/KEY[1], encoded onto HEX4/HEX5.
// Optional feature macro: ENTRY_BLINK_EN (blink selected digit instead of dp marker).

module seven_seg_key_db #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2, db, db_q, armed;
  logic [CW-1:0] cnt;

  // sync flops reset low so a key held through reset never arms the press path
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b1;
      db_q  <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      s1   <= key_n;
      s2   <= s1;
      db_q <= db;
      if (s2) armed <= 1'b1;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        db  <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end

  assign press = armed & db_q & ~db;
endmodule

module seven_seg_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_seg_digit_entry_if.slave  bus
);
  localparam logic [1:0] EDIT_TENS = 2'b01;
  localparam logic [1:0] EDIT_ONES = 2'b10;
  localparam logic [1:0] DONE      = 2'b11;

  if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("DEBOUNCE_CYCLES and BLINK_CYCLES must be >= 1");
  end

  logic [1:0] press;
  logic [1:0] state;
  logic [3:0] tens, ones;
  logic       commit;
  logic [7:0] hex4_q, hex5_q, hex4_d, hex5_d;
  logic [6:0] value_q;
  logic       done_q;
  logic [1:0] ledr_q;

  for (genvar k = 0; k < 2; k++) begin : g_key
    seven_seg_key_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .key_n (bus.KEY[k]),
      .press (press[k])
    );
  end

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  // press[1] has priority; a simultaneous press[0] is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EDIT_TENS;
      tens   <= '0;
      ones   <= '0;
      commit <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        EDIT_TENS: begin
          if (press[1]) state <= EDIT_ONES;
          else if (press[0]) tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end
        EDIT_ONES: begin
          if (press[1]) begin
            state  <= DONE;
            commit <= 1'b1;
          end else if (press[0]) ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
        end
        DONE: if (press[1]) state <= EDIT_TENS;
        default: state <= EDIT_TENS;
      endcase
    end
  end

`ifdef ENTRY_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_CYCLES + 1);
  localparam logic [7:0] HEX4_RST = 8'hC0;

  logic [BW-1:0] blink;
  logic          show;

  always_ff @(posedge clk) begin
    if (rst) blink <= '0;
    else if (blink == BW'(2 * BLINK_CYCLES - 1)) blink <= '0;
    else blink <= blink + 1'b1;
  end

  assign show = (blink < BW'(BLINK_CYCLES));

  always_comb begin
    hex4_d = seg(tens);
    hex5_d = seg(ones);
    if (state == EDIT_TENS && !show) hex4_d = 8'hFF;
    if (state == EDIT_ONES && !show) hex5_d = 8'hFF;
  end
`else
  localparam logic [7:0] HEX4_RST = 8'h40;

  // selected digit marked by its decimal point
  always_comb begin
    hex4_d = seg(tens);
    hex5_d = seg(ones);
    if (state == EDIT_TENS) hex4_d[7] = 1'b0;
    if (state == EDIT_ONES) hex5_d[7] = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hex4_q  <= HEX4_RST;
      hex5_q  <= 8'hC0;
      value_q <= '0;
      done_q  <= 1'b0;
      ledr_q  <= EDIT_TENS;
    end else begin
      hex4_q <= hex4_d;
      hex5_q <= hex5_d;
      done_q <= commit;
      ledr_q <= state;
      if (commit) value_q <= 7'(tens) * 7'd10 + 7'(ones);
    end
  end

  assign bus.HEX4  = hex4_q;
  assign bus.HEX5  = hex5_q;
  assign bus.value = value_q;
  assign bus.done  = done_q;
  assign bus.LEDR  = ledr_q;
endmodule
